// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory,
// tracks granted-but-unanswered requests, buffers responses with their PCs
// and hands them to decode in order. A redirect flushes the buffer, moves the
// fetch PC and arranges for the responses still in flight to be dropped.
//
// Handshakes (all sampled on the rising edge of clk):
//   imem request : a transfer happens when imem_req_o && imem_gnt_i; while
//                  imem_req_o is high and ungranted the address is held, and
//                  the request is withdrawn only in a redirect cycle.
//   imem response: imem_rvalid_i qualifies imem_rdata_i, one per granted
//                  request, in grant order, never in the grant cycle itself.
//   decode       : a word moves when id_valid_o && id_ready_i; id_valid_o
//                  does not depend on id_ready_i.
module instr_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  id_valid_o,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [DATA_WIDTH-1:0] id_pc_o,
  input  logic                  id_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  // Fetch address, always word aligned.
  logic [DATA_WIDTH-1:0] fetch_pc;

  // Requests granted but not yet answered, and how many of those are stale.
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] disc_cnt;
  logic [CNT_W-1:0] out_next;

  // PCs of granted requests, consumed in order as responses return.
  logic [DATA_WIDTH-1:0] req_pc [DEPTH];
  logic [PTR_W-1:0]      pc_wr;
  logic [PTR_W-1:0]      pc_rd;

  // Instruction buffer presented to decode.
  logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc    [DEPTH];
  logic [PTR_W-1:0]      buf_wr;
  logic [PTR_W-1:0]      buf_rd;
  logic [CNT_W-1:0]      buf_cnt;

  logic [CNT_W:0] in_flight;
  logic           grant;
  logic           resp;
  logic           drop;
  logic           push;
  logic           pop;

  // Credit rule: buffered words plus outstanding requests never exceed DEPTH,
  // so every response always has a free buffer slot waiting for it.
  assign in_flight   = {1'b0, buf_cnt} + {1'b0, out_cnt};
  assign imem_req_o  = rst_n && !redirect_valid_i && (in_flight < (CNT_W+1)'(DEPTH));
  assign imem_addr_o = {fetch_pc[DATA_WIDTH-1:2], 2'b00};

  assign grant = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is ignored.
  assign resp  = imem_rvalid_i && (out_cnt != '0);
  assign drop  = resp && (disc_cnt != '0);
  // A redirect flushes the buffer, so a same-cycle response is lost with it.
  assign push  = resp && !drop && !redirect_valid_i;
  assign pop   = id_valid_o && id_ready_i && !redirect_valid_i;

  assign out_next = out_cnt + CNT_W'(grant) - CNT_W'(resp);

  assign id_valid_o = rst_n && (buf_cnt != '0);
  assign id_instr_o = id_valid_o ? buf_instr[buf_rd] : NOP;
  assign id_pc_o    = id_valid_o ? buf_pc[buf_rd]    : '0;

  // Fetch PC: reset vector, redirect target, or +4 per grant (wraps to 0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
    end else if (redirect_valid_i) begin
      fetch_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else if (grant) begin
      fetch_pc <= fetch_pc + DATA_WIDTH'(4);
    end
  end

  // Outstanding and discard counters; a redirect marks everything still in
  // flight (including this cycle's grant, minus this cycle's response) stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      out_cnt <= out_next;
      if (redirect_valid_i) begin
        disc_cnt <= out_next;
      end else if (drop) begin
        disc_cnt <= disc_cnt - CNT_W'(1);
      end
    end
  end

  // Request-PC FIFO pointers: written at grant, read at every response,
  // stale or not, so PCs stay aligned with the response stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_wr <= '0;
      pc_rd <= '0;
    end else begin
      if (grant) pc_wr <= pc_wr + PTR_W'(1);
      if (resp)  pc_rd <= pc_rd + PTR_W'(1);
    end
  end

  // Request-PC FIFO storage.
  always_ff @(posedge clk) begin
    if (grant) req_pc[pc_wr] <= imem_addr_o;
  end

  // Instruction buffer pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid_i) begin
      buf_wr  <= '0;
      buf_rd  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) buf_wr <= buf_wr + PTR_W'(1);
      if (pop)  buf_rd <= buf_rd + PTR_W'(1);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
        2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Instruction buffer storage: the word plus the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[buf_wr] <= imem_rdata_i;
      buf_pc[buf_wr]    <= req_pc[pc_rd];
    end
  end

  // Simulation guard against responses that were never requested.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid_i && (out_cnt == '0)))
        else $error("instr_fetch_queue: imem_rvalid_i with no outstanding request");
    end
  end

endmodule
